// File: rtl/vip_pkg.sv
// vip_pkg: shared widths, threshold default and divider state encoding for the video chain.
package vip_pkg;
    localparam int CNT_W_DEF = 20;
    localparam int SUM_W_DEF = 28;
    localparam logic [7:0] THRESH_INIT_DEF = 8'd128;
    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} div_state_e;
endpackage

// File: rtl/vip_seq_divider.sv
// vip_seq_divider: restoring unsigned divider, one quotient bit per clk, 8-bit saturated result.
module vip_seq_divider
    import vip_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int SUM_W = SUM_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [7:0]       quotient
);
    localparam int BC_W = $clog2(SUM_W + 1);
    div_state_e state, state_nxt;
    logic [SUM_W-1:0] q, q_nxt;
    logic [CNT_W-1:0] dvs, rem;
    logic [CNT_W:0]   rem_sh, rem_sub;
    logic [BC_W-1:0]  bits;
    logic             ge;
    assign rem_sh  = {rem, q[SUM_W-1]};
    assign rem_sub = rem_sh - {1'b0, dvs};
    assign ge      = rem_sh >= {1'b0, dvs};
    assign q_nxt   = {q[SUM_W-2:0], ge};
    assign busy    = state != IDLE;
    // done fires in the last DIV cycle so the result lands on entry to DONE
    assign done     = state == DIV && bits == BC_W'(1);
    assign quotient = |q_nxt[SUM_W-1:8] ? 8'hff : q_nxt[7:0];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = start ? LOAD : IDLE;
            LOAD: state_nxt = dvs == '0 ? IDLE : DIV;
            DIV:  state_nxt = done ? DONE : DIV;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            q    <= '0;
            dvs  <= '0;
            rem  <= '0;
            bits <= '0;
        end else if (state == IDLE && start) begin
            q    <= dividend;
            dvs  <= divisor;
            rem  <= '0;
            bits <= BC_W'(SUM_W);
        end else if (state == DIV) begin
            q    <= q_nxt;
            rem  <= ge ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];
            bits <= bits - BC_W'(1);
        end
endmodule

// File: rtl/vip_ycbcr_auto_binarize.sv
// vip_ycbcr_auto_binarize: binarizes Y against the previous frame's mean luminance.
module vip_ycbcr_auto_binarize
    import vip_pkg::*;
#(
    parameter logic [7:0] THRESH_INIT = THRESH_INIT_DEF,
    parameter int         CNT_W       = CNT_W_DEF,
    parameter int         SUM_W       = SUM_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img_Y,
    input  logic [7:0] per_img_Cb,
    input  logic [7:0] per_img_Cr,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic       post_img_Bit,
    output logic [7:0] post_thresh
);
    logic             vsync_d, fs, fe, pix_en, cnt_full;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             div_busy, div_done, pending_valid;
    logic [7:0]       div_q, active_thresh, pending_thresh, thresh_now;
    logic             unused_chroma;
    assign unused_chroma    = ^{per_img_Cb, per_img_Cr};
    assign fs               = per_frame_vsync & ~vsync_d;
    assign fe               = ~per_frame_vsync & vsync_d;
    assign pix_en           = per_frame_vsync & per_frame_href & per_frame_clken;
    assign cnt_full         = &cnt;
    assign post_frame_vsync = vsync_d;
    assign post_thresh      = active_thresh;
    // a pixel coinciding with FS already sees the threshold being loaded
    assign thresh_now = fs && pending_valid ? pending_thresh : active_thresh;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sum <= '0;
            cnt <= '0;
        end else if (fs) begin
            sum <= SUM_W'(pix_en ? per_img_Y : 8'd0);
            cnt <= CNT_W'(pix_en);
        end else if (pix_en && !cnt_full) begin
            sum <= sum + SUM_W'(per_img_Y);
            cnt <= cnt + CNT_W'(1);
        end
    vip_seq_divider #(.CNT_W(CNT_W), .SUM_W(SUM_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (fe & ~div_busy),
        .dividend (sum),
        .divisor  (cnt),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            active_thresh  <= THRESH_INIT;
            pending_thresh <= THRESH_INIT;
            pending_valid  <= 1'b0;
        end else begin
            if (fs && pending_valid) active_thresh <= pending_thresh;
            if (div_done) begin
                pending_thresh <= div_q;
                pending_valid  <= 1'b1;
            end else if (fs) begin
                pending_valid  <= 1'b0;
            end
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vsync_d          <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_Bit     <= 1'b0;
        end else begin
            vsync_d          <= per_frame_vsync;
            post_frame_href  <= per_frame_href;
            post_frame_clken <= per_frame_clken;
            post_img_Bit     <= per_frame_href & per_frame_clken & (per_img_Y > thresh_now);
        end
endmodule

// File: tb/tb_vip_ycbcr_auto_binarize.sv
// tb_vip_ycbcr_auto_binarize: directed frames with hand-computed thresholds and pixel bits.
module tb_vip_ycbcr_auto_binarize;
    import vip_pkg::*;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       vsync = 1'b0, href = 1'b0, clken = 1'b0;
    logic [7:0] y = 8'd0, cb = 8'd0, cr = 8'd0;
    logic       o_vsync, o_href, o_clken, o_bit;
    logic [7:0] o_thresh;
    logic [7:0] px [8];
    int n_checks = 0, n_fail = 0;

    vip_ycbcr_auto_binarize u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (vsync),
        .per_frame_href   (href),
        .per_frame_clken  (clken),
        .per_img_Y        (y),
        .per_img_Cb       (cb),
        .per_img_Cr       (cr),
        .post_frame_vsync (o_vsync),
        .post_frame_href  (o_href),
        .post_frame_clken (o_clken),
        .post_img_Bit     (o_bit),
        .post_thresh      (o_thresh)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // px[0..n-1] sent back-to-back on one line; exp_bits[i] is the hand-derived bit of pixel i
    task automatic run_frame(input int n, input logic [7:0] th, input logic [7:0] exp_bits,
                             input int blank, input string tag);
        @(negedge clk);
        vsync = 1'b1;
        check({tag, " vsync pre"}, 32'(o_vsync), 32'd0);
        @(negedge clk);
        check({tag, " vsync dly"}, 32'(o_vsync), 32'd1);
        for (int i = 0; i < n; i++) begin
            href = 1'b1; clken = 1'b1; y = px[i];
            @(negedge clk);
            check($sformatf("%s bit%0d", tag, i), 32'(o_bit), 32'(exp_bits[i]));
            check($sformatf("%s href%0d", tag, i), 32'(o_href & o_clken), 32'd1);
            if (i == 0) check({tag, " thresh"}, 32'(o_thresh), 32'(th));
        end
        href = 1'b0; clken = 1'b0;
        @(negedge clk);
        check({tag, " bit idle"}, 32'(o_bit), 32'd0);
        vsync = 1'b0;
        repeat (blank) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst bit", 32'(o_bit), 32'd0);
        check("rst thresh", 32'(o_thresh), 32'd128);
        check("rst sync", 32'({o_vsync, o_href, o_clken}), 32'd0);
        rst_n = 1'b1;
        px = '{8'd129, 8'd128, 0, 0, 0, 0, 0, 0};
        run_frame(2, 8'd128, 8'b01, 40, "A");
        px = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
        run_frame(8, 8'd128, 8'b0, 40, "B");
        px = '{8'd101, 8'd100, 0, 0, 0, 0, 0, 0};
        run_frame(2, 8'd100, 8'b01, 40, "C");
        px = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        run_frame(8, 8'd100, 8'b0, 40, "D");
        px = '{8'd45, 8'd46, 0, 0, 0, 0, 0, 0};
        run_frame(2, 8'd45, 8'b10, 40, "E");
        // empty frame: vsync pulse without any href
        vsync = 1'b1;
        repeat (5) @(negedge clk);
        vsync = 1'b0;
        repeat (40) @(negedge clk);
        check("empty pend", 32'(u_dut.pending_valid), 32'd0);
        check("empty fsm", 32'(u_dut.u_div.state), 32'(IDLE));
        check("empty thresh", 32'(o_thresh), 32'd45);
        // short blanking: G's mean 60 misses H, H's FE arrives mid-division and is dropped
        px = '{8'd60, 8'd60, 8'd60, 8'd60, 0, 0, 0, 0};
        run_frame(4, 8'd45, 8'b1111, 5, "G");
        px = '{8'd50, 8'd40, 0, 0, 0, 0, 0, 0};
        run_frame(2, 8'd45, 8'b01, 40, "H");
        px = '{8'd61, 8'd60, 0, 0, 0, 0, 0, 0};
        run_frame(2, 8'd60, 8'b01, 40, "I");
        px = '{8'd200, 8'd200, 0, 0, 0, 0, 0, 0};
        run_frame(2, 8'd60, 8'b11, 10, "J");
        clken = 1'b1;
        @(negedge clk);
        check("pre-rst busy", 32'(u_dut.div_busy), 32'd1);
        check("pre-rst clken", 32'(o_clken), 32'd1);
        check("pre-rst thresh", 32'(o_thresh), 32'd60);
        #2 rst_n = 1'b0;
        #1;
        check("async thresh", 32'(o_thresh), 32'd128);
        check("async outs", 32'({o_vsync, o_href, o_clken, o_bit}), 32'd0);
        clken = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post-rst pend", 32'(u_dut.pending_valid), 32'd0);
        check("post-rst thresh", 32'(o_thresh), 32'd128);
        px = '{8'd129, 8'd128, 0, 0, 0, 0, 0, 0};
        run_frame(2, 8'd128, 8'b01, 5, "K");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vip_ycbcr_auto_binarize.md
# vip_ycbcr_auto_binarize

Downstream neighbour of the RGB888→YCbCr444 stage in the video image processor chain. Consumes the luminance stream and emits a 1-bit binarized image. The threshold is the mean Y of the previous frame, computed during vertical blanking by a sequential divider. The per-pixel path has single-cycle latency and delays sync/enable signals to match.

## Interface
- THRESH_INIT, 128: threshold used after reset until the first mean is applied.
- CNT_W, 20: pixel counter width; maximum counted pixels per frame is 2^CNT_W−1.
- SUM_W, 28: luminance accumulator width; must be CNT_W+8.
- clk  input  1  pixel clock
- rst_n  input  1  asynchronous, active-low reset
- per_frame_vsync  input  1  high while a frame is active
- per_frame_href  input  1  high while a line is active
- per_frame_clken  input  1  pixel valid strobe
- per_img_Y  input  8  luminance
- per_img_Cb  input  8  unused, accepted for chain compatibility
- per_img_Cr  input  8  unused, accepted for chain compatibility
- post_frame_vsync  output  1  per_frame_vsync delayed 1 clk
- post_frame_href  output  1  per_frame_href delayed 1 clk
- post_frame_clken  output  1  per_frame_clken delayed 1 clk
- post_img_Bit  output  1  1 when Y > active threshold, else 0
- post_thresh  output  8  active threshold (debug/monitor)

## Operation
- **Frame edges.** A registered copy of vsync detects the rising edge (frame start, FS) and the falling edge (frame end, FE) one clk after the input transition.
- **Accumulation.** Runs on each cycle with vsync && href && clken: sum += Y, cnt += 1.
  - When cnt reaches 2^CNT_W−1, both sum and cnt freeze; the mean then covers the counted pixels only.
- **Frame start.** On FS:
  - sum and cnt clear to 0.
  - active_thresh loads pending_thresh if pending_valid is set; pending_valid then clears.
- **Divider FSM states:** IDLE, LOAD, DIV, DONE.
  - IDLE→LOAD on FE: sum/cnt copy into the divider operands.
  - LOAD→IDLE if cnt==0: the threshold stays unchanged and pending_valid is not set.
  - LOAD→DIV otherwise.
  - DIV runs restoring division, one quotient bit per clk, SUM_W clks.
  - DIV→DONE: pending_thresh = quotient saturated to 255, pending_valid = 1.
  - DONE→IDLE next clk.
- **Arithmetic.** Quotient = floor(sum/cnt).
- **Independence from accumulation.** The divider works on its own operand copies, so accumulation of the next frame proceeds concurrently.
- **FE during DIV/LOAD/DONE.** Cannot occur legally. If it does, it is ignored; the running division completes.
- **Threshold update point.** active_thresh never changes mid-frame; it updates only at FS.
  - If a division finishes after FS, its result applies at the following FS.
  - If a newer result arrives before that FS, it overwrites pending_thresh.
- **Pixel path (registered):**
  - post_img_Bit = (href && clken && Y > active_thresh) ? 1 : 0
  - post_thresh = active_thresh
- **Reset (asynchronous, any time including mid-division):**
  - All post_* outputs go to 0, except post_thresh = THRESH_INIT.
  - active_thresh = pending_thresh = THRESH_INIT; pending_valid = 0.
  - FSM = IDLE; sum = cnt = 0; the vsync history register clears.

## Timing
- Pixel path latency is 1 clk, with no bubbles; sync and enable outputs are exact 1-clk delays of the inputs.
- FE is detected 1 clk after vsync falls.
- pending_valid rises SUM_W+2 clks after FE detection: 1 clk LOAD, SUM_W clks DIV, set on entry to DONE.
- The new threshold is used starting with the first pixel of the frame whose FS follows pending_valid.
- Minimum vertical blanking for a next-frame update is SUM_W+4 clks from vsync fall to vsync rise. Shorter blanking delays the update by one frame; it does not corrupt it.

## Structure
- **Shared package vip_pkg:**
  - divider state enum (IDLE, LOAD, DIV, DONE)
  - default widths CNT_W/SUM_W
  - THRESH_INIT default
- **Sub-module vip_seq_divider:** restoring unsigned divider.
  - Ports: start, dividend[SUM_W], divisor[CNT_W], busy, done, quotient[8].
  - Its FSM is the one above.
- The top level holds the edge detect, accumulator, pending/active threshold registers and the pixel pipeline.

## Test plan
- **Reset default.** Release reset, frame of Y=129 and Y=128 → bits 1, 0; post_thresh=128; sync outputs match inputs delayed 1 clk.
- **Uniform frame.** 4×2 frame of Y=100, blanking ≥32 clks, next frame Y=101/100 → post_thresh=100 from FS; bits 1, 0.
- **Mixed frame.** Y=10,20,…,80 (8 px), sum=360 → threshold 45; next frame Y=45 gives 0, Y=46 gives 1.
- **Empty frame.** vsync pulse with no href → threshold unchanged, FSM returns to IDLE without setting pending_valid.
- **Short blanking.** vsync low 5 clks after a frame of mean 60 → the next frame still uses the old threshold; the frame after uses 60.
- **Mid-division reset.** Assert rst_n=0 during DIV → post_thresh=128 and all other post_* outputs 0 immediately; the interrupted result never appears.
